// File: rtl/dec_tree_pkg.sv
// Shared types and helpers for the pipelined select-decoder tree (dec_tree_pipe).
package dec_tree_pkg;

    typedef enum logic {
        DEC_ONEHOT = 1'b0,
        DEC_THERMO = 1'b1
    } dec_mode_e;

    function automatic int unsigned levels(input int unsigned sel_w);
        return sel_w / 2;
    endfunction

endpackage

// File: rtl/dec_tree_pipe_if.sv
// Input/output handshake bundle of dec_tree_pipe; master drives requests, slave is the decoder.
interface dec_tree_pipe_if #(
    parameter int unsigned SEL_W = 6
);
    localparam int unsigned OUT_W = 1 << SEL_W;

    logic             in_valid;
    logic             in_ready;
    logic             in_en;
    logic [SEL_W-1:0] in_sel;
    logic             in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_y;

    modport master (
        output in_valid, in_en, in_sel, in_mode, out_ready,
        input  in_ready, out_valid, out_y
    );

    modport slave (
        input  in_valid, in_en, in_sel, in_mode, out_ready,
        output in_ready, out_valid, out_y
    );

endinterface

// File: rtl/dec_tree_stage.sv
// One registered 2->4 expansion level of the decoder tree with valid/ready flow control.
// In thermometer mode the enable vector is contiguous from bit 0, so its top set bit is the selected group.
module dec_tree_stage
    import dec_tree_pkg::*;
#(
    parameter  int unsigned IN_W    = 1,
    parameter  int unsigned SEL_IN  = 2,
    localparam int unsigned SEL_OUT = (SEL_IN > 2) ? SEL_IN - 2 : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                up_valid,
    output logic                up_ready,
    input  logic [IN_W-1:0]     up_vec,
    input  logic [SEL_IN-1:0]   up_sel,
    input  dec_mode_e           up_mode,
    output logic                dn_valid,
    input  logic                dn_ready,
    output logic [4*IN_W-1:0]   dn_vec,
    output logic [SEL_OUT-1:0]  dn_sel,
    output dec_mode_e           dn_mode
);

    logic [1:0]        digit;
    logic [IN_W:0]     ext;
    logic [4*IN_W-1:0] nxt;
    logic              thermo;
    logic              load;
    logic              hit;
    logic              below;

    assign digit    = up_sel[SEL_IN-1 -: 2];
    assign ext      = {1'b0, up_vec};
    assign thermo   = (up_mode == DEC_THERMO);
    assign load     = !dn_valid || dn_ready;
    assign up_ready = load;

    // Groups below the selected one expand to all ones; the selected group expands by the digit.
    always_comb begin
        nxt   = '0;
        hit   = 1'b0;
        below = 1'b0;
        for (int unsigned j = 0; j < IN_W; j++) begin
            hit   = thermo ? (ext[j] & ~ext[j+1]) : ext[j];
            below = thermo & ext[j] & ext[j+1];
            for (int unsigned m = 0; m < 4; m++) begin
                nxt[4*j+m] = below | (hit & (thermo ? (2'(m) <= digit) : (2'(m) == digit)));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dn_valid <= 1'b0;
            dn_vec   <= '0;
            dn_mode  <= DEC_ONEHOT;
        end else if (load) begin
            dn_valid <= up_valid;
            if (up_valid) begin
                dn_vec  <= nxt;
                dn_mode <= up_mode;
            end
        end
    end

    if (SEL_IN > 2) begin : g_sel
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dn_sel <= '0;
            end else if (load && up_valid) begin
                dn_sel <= up_sel[SEL_IN-3:0];
            end
        end
    end else begin : g_nosel
        assign dn_sel = '0;
    end

endmodule

// File: rtl/dec_tree_pipe.sv
// Pipelined SEL_W-to-2**SEL_W one-hot/thermometer decoder built from SEL_W/2 registered 2->4 levels.
// Optional DEC_TREE_STATS_EN adds dec_count, counting delivered results that had in_en=1.
module dec_tree_pipe
    import dec_tree_pkg::*;
#(
    parameter int unsigned SEL_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    dec_tree_pipe_if.slave     bus
`ifdef DEC_TREE_STATS_EN
    ,
    output logic [31:0]        dec_count
`endif
);

    localparam int unsigned LEVELS = levels(SEL_W);
    localparam int unsigned OUT_W  = 1 << SEL_W;

    if ((SEL_W < 2) || (SEL_W % 2 != 0)) begin : g_bad_param
        $error("dec_tree_pipe: SEL_W must be even and >= 2");
    end

    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int unsigned IN_W    = 1 << (2 * (k - 1));
        localparam int unsigned SEL_IN  = SEL_W - 2 * (k - 1);
        localparam int unsigned SEL_OUT = (SEL_IN > 2) ? SEL_IN - 2 : 1;

        logic                up_valid;
        logic                rdy;
        logic [IN_W-1:0]     up_vec;
        logic [SEL_IN-1:0]   up_sel;
        dec_mode_e           up_mode;
        logic                vld;
        logic                dn_ready;
        logic [4*IN_W-1:0]   vec;
        logic [SEL_OUT-1:0]  sel;
        dec_mode_e           mode;

        if (k == 1) begin : g_head
            assign up_valid = bus.in_valid;
            assign up_vec   = bus.in_en;
            assign up_sel   = bus.in_sel;
            assign up_mode  = dec_mode_e'(bus.in_mode);
        end else begin : g_link
            assign up_valid = g_lvl[k-1].vld;
            assign up_vec   = g_lvl[k-1].vec;
            assign up_sel   = g_lvl[k-1].sel;
            assign up_mode  = g_lvl[k-1].mode;
        end

        if (k == LEVELS) begin : g_tail
            logic [SEL_OUT:0] tail_unused;
            assign dn_ready    = bus.out_ready;
            assign tail_unused = {sel, mode};
        end else begin : g_mid
            assign dn_ready = g_lvl[k+1].rdy;
        end

        dec_tree_stage #(
            .IN_W   (IN_W),
            .SEL_IN (SEL_IN)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .up_valid (up_valid),
            .up_ready (rdy),
            .up_vec   (up_vec),
            .up_sel   (up_sel),
            .up_mode  (up_mode),
            .dn_valid (vld),
            .dn_ready (dn_ready),
            .dn_vec   (vec),
            .dn_sel   (sel),
            .dn_mode  (mode)
        );
    end

    assign bus.in_ready  = g_lvl[1].rdy;
    assign bus.out_valid = g_lvl[LEVELS].vld;
    assign bus.out_y     = g_lvl[LEVELS].vec[OUT_W-1:0];

`ifdef DEC_TREE_STATS_EN
    // An enabled transaction always decodes to a non-zero vector, so |out_y stands in for in_en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_count <= '0;
        end else if (bus.out_valid && bus.out_ready && (|bus.out_y)) begin
            dec_count <= dec_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dec_tree_pipe.sv
// Self-checking bench for dec_tree_pipe (SEL_W=6): table vectors, stall/reset sequences, random traffic.
module tb_dec_tree_pipe;
    import dec_tree_pkg::*;

    localparam int unsigned SEL_W = 6;
    localparam int unsigned OUT_W = 1 << SEL_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dec_tree_pipe_if #(.SEL_W(SEL_W)) bus ();
`ifdef DEC_TREE_STATS_EN
    logic [31:0] dec_count;
`endif

    dec_tree_pipe #(.SEL_W(SEL_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave)
`ifdef DEC_TREE_STATS_EN
        ,
        .dec_count (dec_count)
`endif
    );

    typedef struct {
        logic [OUT_W-1:0] y;
        logic             en;
        int unsigned      cyc;
    } sb_t;

    typedef struct {
        logic             en;
        logic [SEL_W-1:0] sel;
        logic             mode;
        logic [OUT_W-1:0] y;
    } vec_t;

    sb_t              q[$];
    vec_t             tbl[8];
    int               n_cmp = 0;
    int               n_err = 0;
    int               cnt_model = 0;
    int unsigned      cyc = 0;
    int unsigned      n_acc = 0;
    bit               lat_chk = 1'b0;
    bit               prev_stall = 1'b0;
    logic [OUT_W-1:0] prev_y = '0;

    function automatic logic [OUT_W-1:0] ref_y(logic en, logic [SEL_W-1:0] sel, logic mode);
        logic [OUT_W-1:0] y;
        y = '0;
        for (int i = 0; i < int'(OUT_W); i++) begin
            if (en && (mode ? (i <= int'(sel)) : (i == int'(sel)))) y[i] = 1'b1;
        end
        return y;
    endfunction

    task automatic chk(string name, logic [OUT_W-1:0] act, logic [OUT_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cyc_step(logic v, logic en, logic [SEL_W-1:0] sel, logic mode, logic ordy,
                            logic [OUT_W-1:0] exp);
        sb_t e;
        bus.in_valid  = v;
        bus.in_en     = v ? en : 1'bx;
        bus.in_sel    = v ? sel : 'x;
        bus.in_mode   = v ? mode : 1'bx;
        bus.out_ready = ordy;
        #1;
        if (prev_stall) begin
            chk("stall_valid", bus.out_valid, 1);
            chk("stall_y", bus.out_y, prev_y);
        end
        if (bus.out_valid && ordy) begin
            if (q.size() == 0) begin
                chk("spurious_out", bus.out_valid, 0);
            end else begin
                e = q.pop_front();
                chk("out_y", bus.out_y, e.y);
                if (lat_chk) chk("latency", cyc - e.cyc, 3);
                if (e.en) cnt_model++;
            end
        end
        prev_stall = bus.out_valid && !ordy;
        prev_y     = bus.out_y;
        if (v && bus.in_ready) begin
            q.push_back('{y: exp, en: en, cyc: cyc});
            n_acc++;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) cyc_step(0, 0, '0, 0, 1, '0);
        chk("drain_empty", q.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_y", bus.out_y, 0);
        q.delete();
        prev_stall = 1'b0;
        cnt_model  = 0;
        @(posedge clk);
        cyc++;
        #1;
        rst = 1'b0;
        chk("rst_in_ready", bus.in_ready, 1);
`ifdef DEC_TREE_STATS_EN
        chk("rst_dec_count", dec_count, 0);
`endif
    endtask

    initial begin
        logic [OUT_W-1:0] one;
        int unsigned      base;
        logic             ren, rmode, rv, rr;
        logic [SEL_W-1:0] rsel;

        tbl[0] = '{en: 1'b1, sel: 6'h05, mode: 1'b1, y: 64'h0000_0000_0000_003F};
        tbl[1] = '{en: 1'b1, sel: 6'h3F, mode: 1'b1, y: 64'hFFFF_FFFF_FFFF_FFFF};
        tbl[2] = '{en: 1'b1, sel: 6'h00, mode: 1'b1, y: 64'h0000_0000_0000_0001};
        tbl[3] = '{en: 1'b0, sel: 6'h2A, mode: 1'b0, y: 64'h0000_0000_0000_0000};
        tbl[4] = '{en: 1'b0, sel: 6'h2A, mode: 1'b1, y: 64'h0000_0000_0000_0000};
        tbl[5] = '{en: 1'b1, sel: 6'h2A, mode: 1'b0, y: 64'h0000_0400_0000_0000};
        tbl[6] = '{en: 1'b1, sel: 6'h20, mode: 1'b1, y: 64'h0000_0001_FFFF_FFFF};
        tbl[7] = '{en: 1'b1, sel: 6'h3F, mode: 1'b0, y: 64'h8000_0000_0000_0000};

        bus.in_valid  = 1'b0;
        bus.in_en     = 1'b0;
        bus.in_sel    = '0;
        bus.in_mode   = 1'b0;
        bus.out_ready = 1'b1;
        rst           = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // One-hot sweep, back-to-back, fixed latency and full throughput
        lat_chk = 1'b1;
        base    = n_acc;
        one     = 1;
        for (int unsigned s = 0; s < OUT_W; s++) cyc_step(1, 1, SEL_W'(s), 0, 1, one << s);
        chk("sweep_accepts", n_acc - base, OUT_W);
        drain();
        lat_chk = 1'b0;

        foreach (tbl[i]) cyc_step(1, tbl[i].en, tbl[i].sel, tbl[i].mode, 1, tbl[i].y);
        drain();

        // Output stall with a full pipeline: holds, backpressures, then drains in order
        for (int i = 0; i < 3; i++)
            cyc_step(1, 1, SEL_W'(10 + i), 1'(i), 0, ref_y(1, SEL_W'(10 + i), 1'(i)));
        chk("in_ready_full", bus.in_ready, 0);
        base = n_acc;
        for (int i = 0; i < 5; i++) cyc_step(1, 1, 6'h14, 1, 0, ref_y(1, 6'h14, 1));
        chk("stall_no_accept", n_acc - base, 0);
        drain();

        // Reset with three transactions in flight
        for (int i = 0; i < 3; i++) cyc_step(1, 1, SEL_W'(7 * i), 0, 0, ref_y(1, SEL_W'(7 * i), 0));
        do_reset();
        cyc_step(1, 1, 6'h2A, 1, 1, ref_y(1, 6'h2A, 1));
        drain();

        // Ten transactions, two disabled
        do_reset();
        for (int i = 0; i < 10; i++) begin
            ren = (i != 3) && (i != 7);
            cyc_step(1, ren, SEL_W'(5 * i), 1'(i % 2), 1, ref_y(ren, SEL_W'(5 * i), 1'(i % 2)));
        end
        drain();
`ifdef DEC_TREE_STATS_EN
        chk("dec_count_10", dec_count, 8);
`endif

        for (int i = 0; i < 400; i++) begin
            rv    = ($urandom_range(0, 9) < 7);
            rr    = ($urandom_range(0, 9) < 7);
            ren   = ($urandom_range(0, 9) < 8);
            rmode = 1'($urandom);
            rsel  = SEL_W'($urandom);
            cyc_step(rv, ren, rsel, rmode, rr, ref_y(ren, rsel, rmode));
        end
        drain();
`ifdef DEC_TREE_STATS_EN
        chk("dec_count_rand", dec_count, cnt_model);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
